// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared constants and state encoding for the modular arithmetic units
package mod_pkg;

  localparam int WIDTH_DEF = 256;
  localparam int ITER      = 2 * WIDTH_DEF;

  localparam logic [1:0] TM_IDLE = 2'd0;
  localparam logic [1:0] TM_RUN  = 2'd1;
  localparam logic [1:0] TM_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = TM_IDLE,
    S_RUN  = TM_RUN,
    S_DONE = TM_DONE
  } tm_state_t;

endpackage

// File: rtl/to_mont_if.sv
// rtl/to_mont_if.sv - start/result pulse handshake bundle for to_mont (err only with TO_MONT_CHECK_EN)
interface to_mont_if #(parameter int WIDTH = mod_pkg::WIDTH_DEF);

  logic             in_valid;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opM;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef TO_MONT_CHECK_EN
  logic             err;

  modport master (output in_valid, opA, opM,
                  input  in_ready, out_valid, out_data, err);
  modport slave  (input  in_valid, opA, opM,
                  output in_ready, out_valid, out_data, err);
`else
  modport master (output in_valid, opA, opM,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, opA, opM,
                  output in_ready, out_valid, out_data);
`endif

endinterface

// File: rtl/mod_dbl_step.sv
// rtl/mod_dbl_step.sv - combinational (2r + bit) mod m step, valid when r < m
module mod_dbl_step #(
  parameter int WIDTH = mod_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r_next
);

  // t < 2m, so one conditional subtract restores r < m; the extra bit keeps 2r from overflowing.
  logic [WIDTH:0] t;
  logic [WIDTH:0] mm;
  logic           ge;

  assign t  = {r, bit_in};
  assign mm = {1'b0, m};
  assign ge = (t >= mm);

  // When t < m its top bit is zero, so dropping it is lossless.
  assign r_next = ge ? WIDTH'(t - mm) : t[WIDTH-1:0];

endmodule

// File: rtl/to_mont.sv
// rtl/to_mont.sv - bit-serial conversion into Montgomery form, out = opA*2^WIDTH mod opM; TO_MONT_CHECK_EN adds modulus check and err
module to_mont
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  to_mont_if.slave   bus
);

  localparam int ITERS = 2 * WIDTH;
  localparam int CW    = $clog2(ITERS) + 1;

  tm_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_step;
  logic             last;
  logic             abort;

  // The low WIDTH bits of {opA, 0} are zeros, so only opA is stored and zeros shift in behind it.
  mod_dbl_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .bit_in (sh[WIDTH-1]),
    .m      (m),
    .r_next (r_step)
  );

  assign last        = (cnt == CW'(ITERS));
  assign bus.in_ready = (state == S_IDLE);

`ifdef TO_MONT_CHECK_EN
  // Montgomery form needs an odd modulus of at least 3; bad jobs leave RUN on its first cycle.
  assign abort = (m < WIDTH'(2)) || !m[0];
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_RUN;
      S_RUN:   if (last || abort) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, one Horner iteration per RUN cycle, and the registered result pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      sh            <= '0;
      m             <= '0;
      r             <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`ifdef TO_MONT_CHECK_EN
      bus.err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sh  <= bus.opA;
            m   <= bus.opM;
            r   <= '0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= '0;
`ifdef TO_MONT_CHECK_EN
            bus.err       <= 1'b1;
`endif
          end else if (last) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= r;
`ifdef TO_MONT_CHECK_EN
            bus.err       <= 1'b0;
`endif
          end else begin
            r   <= r_step;
            sh  <= sh << 1;
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.out_data  <= '0;
`ifdef TO_MONT_CHECK_EN
          bus.err       <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
